// File: rtl/spi_reg_file.sv
// spi_reg_file: SPI-facing register bank with sticky faults, config bytes and a link-loss watchdog gating global_en
module spi_reg_file #(
   parameter logic [7:0] DEVICE_ID     = 8'hB5,
   parameter int         WDOG_PRESCALE = 50000
) (
   input  logic         clock,
   input  logic         reset_n,
   input  logic [5:0]   address,
   input  logic         write_en,
   input  logic [7:0]   wr_data,
   input  logic         read_en,
   input  logic [7:0]   fault_in,
   input  logic [127:0] status_in,
   output logic [7:0]   rd_data,
   output logic [255:0] cfg_out,
   output logic         global_en,
   output logic         wdog_timeout,
   output logic         irq
);
   localparam int PW = $clog2(WDOG_PRESCALE);
   logic          ctrl_en;
   logic [7:0]    fault, fault_n, fault_q, wdog_limit, wdog_cnt, wdog_cnt_n, rd_mux;
   logic [PW-1:0] presc, presc_n;
   logic          access, tick, wr_ctrl, soft_clr, timeout_n;
   assign access   = write_en | read_en;
   assign wr_ctrl  = write_en && address == 6'h01;
   assign soft_clr = wr_ctrl & wr_data[1];
   assign tick     = presc == PW'(WDOG_PRESCALE - 1);
   always_comb begin
      rd_mux = 8'h00;
      if (address[5])
         rd_mux = cfg_out[{address[4:0], 3'b000} +: 8];
      else if (address[4])
         rd_mux = status_in[{address[3:0], 3'b000} +: 8];
      else
         case (address[3:0])
            4'h0:    rd_mux = DEVICE_ID;
            4'h1:    rd_mux = {7'b0, ctrl_en};
            4'h2:    rd_mux = {6'b0, irq, wdog_timeout};
            4'h3:    rd_mux = fault;
            4'h4:    rd_mux = wdog_limit;
            default: rd_mux = 8'h00;
         endcase
   end
   always_comb begin
      fault_n    = ((soft_clr ? 8'h00 : fault) & ~((write_en && address == 6'h03) ? wr_data : 8'h00))
                   | (fault_in & ~fault_q);
      presc_n    = (access || tick) ? '0 : presc + PW'(1);
      wdog_cnt_n = (access || wdog_limit == 8'd0) ? 8'd0
                   : (tick && wdog_cnt != 8'hFF) ? wdog_cnt + 8'd1 : wdog_cnt;
      timeout_n  = wr_ctrl ? 1'b0 : wdog_timeout | (wdog_limit != 8'd0 && wdog_cnt_n == wdog_limit);
   end
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         rd_data      <= 8'h00;
         cfg_out      <= '0;
         global_en    <= 1'b0;
         wdog_timeout <= 1'b0;
         irq          <= 1'b0;
         ctrl_en      <= 1'b0;
         fault        <= 8'h00;
         fault_q      <= 8'h00;
         wdog_limit   <= 8'h00;
         wdog_cnt     <= 8'h00;
         presc        <= '0;
      end else begin
         fault_q      <= fault_in;
         fault        <= fault_n;
         irq          <= |fault_n;
         presc        <= presc_n;
         wdog_cnt     <= wdog_cnt_n;
         wdog_timeout <= timeout_n;
         global_en    <= ctrl_en & ~wdog_timeout;
         if (wr_ctrl)
            ctrl_en <= wr_data[0];
         if (write_en && address == 6'h04)
            wdog_limit <= wr_data;
         if (soft_clr)
            cfg_out <= '0;
         else if (write_en && address[5])
            cfg_out[{address[4:0], 3'b000} +: 8] <= wr_data;
         if (read_en && !write_en)
            rd_data <= rd_mux;
      end
   end
endmodule
